// File: rtl/result_forward_pipe_if.sv
// Bus bundle for result_forward_pipe: issue inputs, operand-fetch bypass ports and writeback.
// The master drives issue/read inputs; the slave is the pipeline.
interface result_forward_pipe_if #(
    parameter int unsigned REG_WIDTH  = 128,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned LAT_WIDTH  = 3
);
    logic                  flush;

    logic                  even_res_valid;
    logic [ADDR_WIDTH-1:0] even_res_addr;
    logic [REG_WIDTH-1:0]  even_res_data;
    logic [LAT_WIDTH-1:0]  even_res_lat;
    logic                  odd_res_valid;
    logic [ADDR_WIDTH-1:0] odd_res_addr;
    logic [REG_WIDTH-1:0]  odd_res_data;
    logic [LAT_WIDTH-1:0]  odd_res_lat;

    logic [ADDR_WIDTH-1:0] addr_ra_rd_even, addr_rb_rd_even, addr_rc_rd_even;
    logic [ADDR_WIDTH-1:0] addr_ra_rd_odd, addr_rb_rd_odd;
    logic [REG_WIDTH-1:0]  rf_ra_even, rf_rb_even, rf_rc_even, rf_ra_odd, rf_rb_odd;

    logic [REG_WIDTH-1:0]  op_ra_even, op_rb_even, op_rc_even, op_ra_odd, op_rb_odd;
    logic                  haz_ra_even, haz_rb_even, haz_rc_even, haz_ra_odd, haz_rb_odd;

    logic                  wr_en_even, wr_en_odd;
    logic [ADDR_WIDTH-1:0] addr_rt_wt_even, addr_rt_wt_odd;
    logic [REG_WIDTH-1:0]  rt_wt_even, rt_wt_odd;

    modport master (
        output flush,
        output even_res_valid, even_res_addr, even_res_data, even_res_lat,
        output odd_res_valid, odd_res_addr, odd_res_data, odd_res_lat,
        output addr_ra_rd_even, addr_rb_rd_even, addr_rc_rd_even, addr_ra_rd_odd, addr_rb_rd_odd,
        output rf_ra_even, rf_rb_even, rf_rc_even, rf_ra_odd, rf_rb_odd,
        input  op_ra_even, op_rb_even, op_rc_even, op_ra_odd, op_rb_odd,
        input  haz_ra_even, haz_rb_even, haz_rc_even, haz_ra_odd, haz_rb_odd,
        input  wr_en_even, addr_rt_wt_even, rt_wt_even,
        input  wr_en_odd, addr_rt_wt_odd, rt_wt_odd
    );

    modport slave (
        input  flush,
        input  even_res_valid, even_res_addr, even_res_data, even_res_lat,
        input  odd_res_valid, odd_res_addr, odd_res_data, odd_res_lat,
        input  addr_ra_rd_even, addr_rb_rd_even, addr_rc_rd_even, addr_ra_rd_odd, addr_rb_rd_odd,
        input  rf_ra_even, rf_rb_even, rf_rc_even, rf_ra_odd, rf_rb_odd,
        output op_ra_even, op_rb_even, op_rc_even, op_ra_odd, op_rb_odd,
        output haz_ra_even, haz_rb_even, haz_rc_even, haz_ra_odd, haz_rb_odd,
        output wr_en_even, addr_rt_wt_even, rt_wt_even,
        output wr_en_odd, addr_rt_wt_odd, rt_wt_odd
    );
endinterface

// File: rtl/result_forward_pipe.sv
// Dual-pipe result shift pipeline: results age DEPTH stages before register-file writeback,
// with youngest-producer operand bypass and RAW hazard flagging.
module result_forward_pipe #(
    parameter int unsigned REG_WIDTH  = 128,
    parameter int unsigned REG_COUNT  = 128,
    parameter int unsigned DEPTH      = 7,
    parameter int unsigned KILL_DEPTH = 3,
    parameter int unsigned LAT_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    result_forward_pipe_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT);
    localparam int unsigned STG_W      = $clog2(DEPTH + 1);
    localparam int unsigned NPIPE      = 2;
    localparam int unsigned NRD        = 5;

    // Index 0 is the even pipe, 1 the odd pipe; stage s lives at index s-1.
    logic [NPIPE-1:0][DEPTH-1:0] valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]       addr_q [NPIPE][DEPTH];
    logic [ADDR_WIDTH-1:0]       addr_d [NPIPE][DEPTH];
    logic [REG_WIDTH-1:0]        data_q [NPIPE][DEPTH];
    logic [REG_WIDTH-1:0]        data_d [NPIPE][DEPTH];
    logic [STG_W-1:0]            lat_q  [NPIPE][DEPTH];
    logic [STG_W-1:0]            lat_d  [NPIPE][DEPTH];

    logic                        in_valid [NPIPE];
    logic [ADDR_WIDTH-1:0]       in_addr  [NPIPE];
    logic [REG_WIDTH-1:0]        in_data  [NPIPE];
    logic [LAT_WIDTH-1:0]        in_lat   [NPIPE];

    logic [ADDR_WIDTH-1:0]       rd_addr  [NRD];
    logic [REG_WIDTH-1:0]        rf_data  [NRD];
    logic                        fwd_hit  [NRD];
    logic                        fwd_rdy  [NRD];
    logic [REG_WIDTH-1:0]        fwd_data [NRD];
    logic [REG_WIDTH-1:0]        op_c     [NRD];
    logic                        haz_c    [NRD];

    assign in_valid[0] = bus.even_res_valid;
    assign in_addr[0]  = bus.even_res_addr;
    assign in_data[0]  = bus.even_res_data;
    assign in_lat[0]   = bus.even_res_lat;
    assign in_valid[1] = bus.odd_res_valid;
    assign in_addr[1]  = bus.odd_res_addr;
    assign in_data[1]  = bus.odd_res_data;
    assign in_lat[1]   = bus.odd_res_lat;

    assign rd_addr[0] = bus.addr_ra_rd_even;
    assign rd_addr[1] = bus.addr_rb_rd_even;
    assign rd_addr[2] = bus.addr_rc_rd_even;
    assign rd_addr[3] = bus.addr_ra_rd_odd;
    assign rd_addr[4] = bus.addr_rb_rd_odd;
    assign rf_data[0] = bus.rf_ra_even;
    assign rf_data[1] = bus.rf_rb_even;
    assign rf_data[2] = bus.rf_rc_even;
    assign rf_data[3] = bus.rf_ra_odd;
    assign rf_data[4] = bus.rf_rb_odd;

    // Latency is clamped to 1..DEPTH once at issue so the ready test is a plain compare.
    function automatic logic [STG_W-1:0] eff_lat(input logic [LAT_WIDTH-1:0] lat);
        if (lat == '0)
            return STG_W'(1);
        if (int'(lat) > int'(DEPTH))
            return STG_W'(DEPTH);
        return STG_W'(lat);
    endfunction

    // Shift network: a flush kills the issue slot and everything currently in stages 1..KILL_DEPTH.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lat_d   = lat_q;
        for (int p = 0; p < int'(NPIPE); p++) begin
            valid_d[p][0] = in_valid[p] && !bus.flush;
            addr_d[p][0]  = in_addr[p];
            data_d[p][0]  = in_data[p];
            lat_d[p][0]   = eff_lat(in_lat[p]);
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_d[p][i] = valid_q[p][i-1] && !(bus.flush && (i <= int'(KILL_DEPTH)));
                addr_d[p][i]  = addr_q[p][i-1];
                data_d[p][i]  = data_q[p][i-1];
                lat_d[p][i]   = lat_q[p][i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        lat_q  <= lat_d;
    end

    // Oldest-to-youngest scan so the last match (lowest stage, even on a tie) wins.
    always_comb begin
        for (int r = 0; r < int'(NRD); r++) begin
            fwd_hit[r]  = 1'b0;
            fwd_rdy[r]  = 1'b0;
            fwd_data[r] = '0;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                for (int p = int'(NPIPE) - 1; p >= 0; p--) begin
                    if (valid_q[p][i] && (addr_q[p][i] == rd_addr[r])) begin
                        fwd_hit[r]  = 1'b1;
                        fwd_rdy[r]  = int'(lat_q[p][i]) <= (i + 1);
                        fwd_data[r] = data_q[p][i];
                    end
                end
            end
            op_c[r]  = (fwd_hit[r] && fwd_rdy[r]) ? fwd_data[r] : rf_data[r];
            haz_c[r] = fwd_hit[r] && !fwd_rdy[r];
        end
    end

    assign bus.op_ra_even  = op_c[0];
    assign bus.op_rb_even  = op_c[1];
    assign bus.op_rc_even  = op_c[2];
    assign bus.op_ra_odd   = op_c[3];
    assign bus.op_rb_odd   = op_c[4];
    assign bus.haz_ra_even = haz_c[0];
    assign bus.haz_rb_even = haz_c[1];
    assign bus.haz_rc_even = haz_c[2];
    assign bus.haz_ra_odd  = haz_c[3];
    assign bus.haz_rb_odd  = haz_c[4];

    assign bus.wr_en_even      = valid_q[0][DEPTH-1];
    assign bus.addr_rt_wt_even = valid_q[0][DEPTH-1] ? addr_q[0][DEPTH-1] : '0;
    assign bus.rt_wt_even      = valid_q[0][DEPTH-1] ? data_q[0][DEPTH-1] : '0;
    assign bus.wr_en_odd       = valid_q[1][DEPTH-1];
    assign bus.addr_rt_wt_odd  = valid_q[1][DEPTH-1] ? addr_q[1][DEPTH-1] : '0;
    assign bus.rt_wt_odd       = valid_q[1][DEPTH-1] ? data_q[1][DEPTH-1] : '0;
endmodule
